// File: rtl/sample_readout.sv
// Per-channel sample FIFOs, read out on request as a framed byte stream:
// header {A, channel}, sample count, then the samples oldest first.
module sample_readout #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [7:0]        wr_data,
  input  logic              rd_req,
  input  logic [3:0]        rd_ch,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [NUM_CH-1:0] ovf
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [3:0]           ch_q, ch_d;
  logic [CW-1:0]        rem_q, rem_d;
  logic [NUM_CH*CW-1:0] cnt_all;
  logic [NUM_CH*8-1:0]  head_all;
  logic [CW-1:0]        snap_cnt;
  logic [7:0]           head_sel;
  logic                 pop_en;
  logic                 hdr_done;

  assign busy      = (state_q != IDLE);
  assign out_valid = busy;
  assign pop_en    = (state_q == DATA) && out_ready;
  assign hdr_done  = (state_q == HDR) && out_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          mine, hit, full, do_wr, do_pop;

    assign mine   = (ch_q == 4'(gi));
    assign hit    = wr_en && (wr_ch == 4'(gi));
    assign full   = (cnt_q == CW'(DEPTH));
    assign do_wr  = hit && !full;
    assign do_pop = pop_en && mine;

    // A same-cycle pop never makes room for a write that arrives while full.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (do_wr)  wp_q <= wp_q + PW'(1);
        if (do_pop) rp_q <= rp_q + PW'(1);
        if (do_wr && !do_pop)      cnt_q <= cnt_q + CW'(1);
        else if (!do_wr && do_pop) cnt_q <= cnt_q - CW'(1);
        if (hit && full)           ovf_q <= 1'b1;
        else if (hdr_done && mine) ovf_q <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (do_wr) mem_q[wp_q] <= wr_data;
    end

    assign cnt_all[gi*CW +: CW] = cnt_q;
    assign head_all[gi*8 +: 8]  = mem_q[rp_q];
    assign ovf[gi]              = ovf_q;
  end

  // Out-of-range channels match nothing, so they snapshot a length of zero.
  always_comb begin
    snap_cnt = '0;
    head_sel = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 4'(i)) snap_cnt = cnt_all[i*CW +: CW];
      if (ch_q == 4'(i))  head_sel = head_all[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = HDR;
          ch_d    = rd_ch;
          rem_d   = snap_cnt;
        end
      end
      HDR: begin
        if (out_ready) state_d = CNT;
      end
      CNT: begin
        if (out_ready) state_d = (rem_q == '0) ? IDLE : DATA;
      end
      default: begin
        if (out_ready) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    case (state_q)
      HDR:     out_data = {4'hA, ch_q};
      CNT:     out_data = 8'(rem_q);
      DATA:    out_data = head_sel;
      default: out_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= 4'h0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_sample_readout.sv
// Scoreboard bench for sample_readout: frame bytes are queued when a read is
// requested and compared as each byte is accepted by the consumer.
module tb_sample_readout;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [3:0]        wr_ch = 4'h0;
  logic [7:0]        wr_data = 8'h00;
  logic              rd_req = 1'b0;
  logic [3:0]        rd_ch = 4'h0;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              busy;
  logic [NUM_CH-1:0] ovf;

  int                checks = 0;
  int                failures = 0;
  logic [7:0]        sb_q [$];
  logic [7:0]        mq [NUM_CH][$];
  logic [NUM_CH-1:0] ovf_m = '0;
  logic              stall_prev = 1'b0;
  logic [7:0]        stall_data = 8'h00;

  always #5 clk = ~clk;

  sample_readout #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_ch     (rd_ch),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Consumer side: every accepted byte is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && out_valid) chk("stall_stable", {24'h0, out_data}, {24'h0, stall_data});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte got=0x%02h exp=none", out_data);
        end else begin
          logic [7:0] e;
          e = sb_q.pop_front();
          chk("frame_byte", {24'h0, out_data}, {24'h0, e});
          $display("rx byte 0x%02h exp 0x%02h", out_data, e);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_ch   = 4'(ch);
    wr_data = d;
    step();
    wr_en = 1'b0;
    if (ch < NUM_CH) begin
      if (mq[ch].size() < DEPTH) mq[ch].push_back(d);
      else ovf_m[ch] = 1'b1;
    end
    $display("write ch=%0d data=0x%02h", ch, d);
  endtask

  task automatic start_frame(input int ch);
    int n;
    n = (ch < NUM_CH) ? mq[ch].size() : 0;
    sb_q.push_back(8'hA0 | 8'(ch));
    sb_q.push_back(8'(n));
    for (int i = 0; i < n; i++) sb_q.push_back(mq[ch].pop_front());
    if (ch < NUM_CH) ovf_m[ch] = 1'b0;
    rd_req = 1'b1;
    rd_ch  = 4'(ch);
    step();
    rd_req = 1'b0;
    $display("frame request ch=%0d n=%0d", ch, n);
  endtask

  // exp_cyc < 0 skips the frame-length timing check.
  task automatic wait_idle(input int exp_cyc);
    int cyc;
    cyc = 0;
    while (busy && cyc < 200) begin
      step();
      cyc++;
    end
    chk("idle_reached", {31'h0, busy}, 32'h0);
    if (exp_cyc >= 0) chk("frame_cycles", cyc, exp_cyc);
    chk("sb_drained", sb_q.size(), 32'h0);
    chk("ovf_model", {28'h0, ovf}, {28'h0, ovf_m});
  endtask

  initial begin
    int ch;
    int n;
    int k;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovf", {28'h0, ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic three-sample frame
    wr(2, 8'h11);
    wr(2, 8'h22);
    wr(2, 8'h33);
    start_frame(2);
    wait_idle(5);

    // Empty and out-of-range channels
    start_frame(1);
    wait_idle(2);
    start_frame(7);
    wait_idle(2);

    // Writes to a nonexistent channel change nothing
    wr(5, 8'h99);
    chk("ignored_wr_ovf", {28'h0, ovf}, 32'h0);
    start_frame(5);
    wait_idle(2);

    // Overflow: ninth sample dropped, flag cleared by the header handshake
    for (int i = 1; i <= 9; i++) wr(0, 8'(i));
    chk("ovf_set", {28'h0, ovf}, 32'h1);
    start_frame(0);
    wait_idle(10);
    chk("ovf_cleared", {28'h0, ovf}, 32'h0);

    // Back-pressure during DATA
    for (int i = 0; i < 4; i++) wr(1, 8'hA1 + 8'(i));
    start_frame(1);
    step();
    step();
    begin
      logic [3:0] pat;
      pat = 4'b1001;
      for (int i = 3; i >= 0; i--) begin
        out_ready = pat[i];
        step();
      end
    end
    out_ready = 1'b1;
    wait_idle(-1);

    // Write during a frame of the same channel stays for the next frame
    wr(3, 8'h31);
    wr(3, 8'h32);
    start_frame(3);
    wr(3, 8'h55);
    wait_idle(-1);
    start_frame(3);
    wait_idle(3);

    // Write and pop on the same edge
    wr(3, 8'h71);
    wr(3, 8'h72);
    start_frame(3);
    step();
    step();
    wr(3, 8'h73);
    wait_idle(-1);
    start_frame(3);
    wait_idle(3);

    // Mixed random traffic
    for (int r = 0; r < 6; r++) begin
      ch = $urandom_range(0, NUM_CH);
      k  = $urandom_range(0, 10);
      for (int i = 0; i < k; i++) wr(ch, 8'($urandom_range(0, 255)));
      ch = $urandom_range(0, NUM_CH + 1);
      n  = (ch < NUM_CH) ? mq[ch].size() : 0;
      start_frame(ch);
      wait_idle(n + 2);
    end

    // Reset in the middle of DATA
    wr(0, 8'hC1);
    wr(0, 8'hC2);
    wr(0, 8'hC3);
    start_frame(0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_data", {24'h0, out_data}, 32'h0);
    sb_q.delete();
    for (int i = 0; i < NUM_CH; i++) mq[i].delete();
    ovf_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_frame(0);
    wait_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_readout.md
SAMPLE_READOUT -- requirements
Module: sample_readout

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sample channels (1..16).
REQ-002 SHALL have parameter DEPTH, default 8: samples stored per channel (power of 2, 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe for one 8-bit sample.
REQ-006 SHALL have port wr_ch  input  4  target channel of the write.
REQ-007 SHALL have port wr_data  input  8  sample value.
REQ-008 SHALL have port rd_req  input  1  request to read out one channel as a frame.
REQ-009 SHALL have port rd_ch  input  4  channel to read out, sampled with rd_req.
REQ-010 SHALL have port out_data  output  8  frame byte.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts byte when high with out_valid.
REQ-013 SHALL have port busy  output  1  high while a frame is in progress.
REQ-014 SHALL have port ovf  output  NUM_CH  per-channel sticky overflow flag.

Function
REQ-015 SHALL keep one circular FIFO per channel: write pointer, read pointer, count 0..DEPTH.
REQ-016 SHALL, on wr_en with wr_ch < NUM_CH and count < DEPTH, store wr_data and increment count the same edge.
REQ-017 SHALL, on wr_en with count == DEPTH, drop the sample, leave the FIFO unchanged and set ovf[wr_ch]; a pop in the same cycle does not free space for that write.
REQ-018 SHALL ignore wr_en with wr_ch >= NUM_CH (no state change, no flag).
REQ-019 SHALL implement FSM states IDLE, HDR, CNT, DATA; busy = (state != IDLE).
REQ-020 SHALL, in IDLE on rd_req, latch rd_ch, snapshot that channel's count into a frame length N (0 if rd_ch >= NUM_CH), and go to HDR next cycle.
REQ-021 SHALL ignore rd_req while busy is high.
REQ-022 SHALL in HDR drive out_valid=1, out_data = {4'hA, latched channel}; on handshake go to CNT and clear ovf of that channel (if valid channel); a write overflow in the same cycle wins and keeps the flag set.
REQ-023 SHALL in CNT drive out_valid=1, out_data = N zero-extended to 8 bits; on handshake go to DATA if N>0 else IDLE.
REQ-024 SHALL in DATA drive out_valid=1, out_data = oldest sample of the channel; each handshake pops one sample (count-1, read pointer+1); after the Nth handshake go to IDLE.
REQ-025 SHALL emit exactly N data bytes; samples written to the channel during the frame remain stored for the next frame.
REQ-026 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL allow a write and a pop on the same channel in one cycle (count unchanged net, when not full).
REQ-028 SHALL wrap pointers modulo DEPTH.
REQ-029 SHALL drive out_valid=0 and out_data=8'h00 in IDLE.
REQ-030 SHALL achieve one byte per cycle with out_ready held high: frame of N samples takes N+2 cycles after leaving IDLE.

Reset
REQ-031 SHALL, on rst_n low, immediately clear all counts and pointers, ovf=0, state=IDLE, out_valid=0, out_data=8'h00, busy=0.
REQ-032 SHALL abort any frame in progress on reset; unread samples are discarded.
REQ-033 SHALL not require sample storage contents to be reset.

Verification
REQ-034 SHALL pass: write 0x11,0x22,0x33 to ch 2, rd_req ch 2, out_ready=1 -> bytes 0xA2,0x03,0x11,0x22,0x33 on consecutive cycles, busy low after.
REQ-035 SHALL pass: rd_req ch 1 with empty FIFO -> bytes 0xA1,0x00 then IDLE; rd_req ch 7 (NUM_CH=4) -> 0xA7,0x00.
REQ-036 SHALL pass: 9 writes (0x01..0x09) to ch 0 -> ovf=0001, frame 0xA0,0x08,0x01..0x08; ovf=0 after header handshake.
REQ-037 SHALL pass: out_ready toggled 1,0,0,1 during DATA -> out_data stable during stall, no sample lost or duplicated.
REQ-038 SHALL pass: write 0x55 to ch 3 during a ch 3 frame with N=2 -> frame carries 2 samples; next frame 0xA3,0x01,0x55.
REQ-039 SHALL pass: rst_n low mid-DATA -> out_valid=0, busy=0 asynchronously; subsequent read of that channel returns count 0x00.
